// File: rtl/fir_coeff_loader.sv
// Loads the symmetric half-coefficient set of the polyphase FIR interpolator from a
// host valid/ready stream, verifies a trailing checksum and supervises timeout/abort.
module fir_coeff_loader #(
   parameter int  ORD        = 255,
   parameter int  COEFF_SIZE = 16,
   parameter int  TIMEOUT    = 1024,
   localparam int NCOEFF     = (ORD + 1) / 2,
   localparam int AW         = $clog2((ORD + 1) / 2)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [COEFF_SIZE-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  c_we,
   output logic [AW-1:0]         c_addr,
   output logic [COEFF_SIZE-1:0] c_in,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            err_code,
   output logic                  coeff_ok
);

   typedef enum logic [1:0] {IDLE, LOAD, CSUM} state_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_ABORT   = 2'd3
   } err_t;

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [AW:0] LAST_WORD = (AW + 1)'(NCOEFF - 1);

   state_t                state;
   logic [AW:0]           wcnt;
   logic [COEFF_SIZE-1:0] csum;
   logic [TW-1:0]         tcnt;
   logic                  accept;
   logic                  timed_out;

   // The only combinational output: the host sees abort withdraw readiness in the same cycle.
   assign s_ready   = (state != IDLE) && !abort;
   assign accept    = s_valid && s_ready;
   // Fires on the idle cycle that brings the counter to TIMEOUT, so IDLE follows immediately.
   assign timed_out = (TIMEOUT > 0) && !accept && (tcnt == TW'(TIMEOUT - 1));

   // NOTE: every register here is state, so all assignments are non-blocking; done
   // defaults low each cycle to make it a single-cycle pulse.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         wcnt     <= '0;
         csum     <= '0;
         tcnt     <= '0;
         c_we     <= 1'b0;
         c_addr   <= '0;
         c_in     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err_code <= ERR_OK;
         coeff_ok <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  wcnt     <= '0;
                  csum     <= '0;
                  tcnt     <= '0;
                  c_we     <= 1'b1;
                  c_addr   <= '0;
                  c_in     <= '0;
                  busy     <= 1'b1;
                  err_code <= ERR_OK;
                  coeff_ok <= 1'b0;
               end
            end
            LOAD, CSUM: begin
               if (abort) begin
                  state    <= IDLE;
                  c_we     <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  err_code <= ERR_ABORT;
                  coeff_ok <= 1'b0;
               end else if (accept) begin
                  tcnt <= '0;
                  if (state == LOAD) begin
                     c_addr <= wcnt[AW-1:0];
                     c_in   <= s_data;
                     csum   <= csum + s_data;
                     wcnt   <= wcnt + 1'b1;
                     if (wcnt == LAST_WORD) state <= CSUM;
                  end else begin
                     state    <= IDLE;
                     c_we     <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     err_code <= (s_data == csum) ? ERR_OK : ERR_CSUM;
                     coeff_ok <= (s_data == csum);
                  end
               end else if (timed_out) begin
                  state    <= IDLE;
                  c_we     <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  err_code <= ERR_TIMEOUT;
                  coeff_ok <= 1'b0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomised self-checking bench for fir_coeff_loader; a behavioural model of the
// coefficient memory and checksum supplies every expected value.
module tb_fir_coeff_loader;

   localparam int ORD     = 255;
   localparam int CW      = 16;
   localparam int TIMEOUT = 1024;
   localparam int NC      = (ORD + 1) / 2;
   localparam int AW      = $clog2(NC);

   logic          clk = 1'b0;
   logic          nrst;
   logic          start;
   logic          abort;
   logic [CW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [CW-1:0] c_in;
   logic          busy;
   logic          done;
   logic [1:0]    err_code;
   logic          coeff_ok;

   int total = 0;
   int bad   = 0;

   logic [CW-1:0] words [$];
   logic [CW-1:0] tb_mem [NC];

   fir_coeff_loader #(.ORD(ORD), .COEFF_SIZE(CW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .nrst(nrst), .start(start), .abort(abort),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .c_we(c_we), .c_addr(c_addr), .c_in(c_in),
      .busy(busy), .done(done), .err_code(err_code), .coeff_ok(coeff_ok)
   );

   always #5 clk = ~clk;

   // Interpolator coefficient memory as seen from its write port.
   always @(posedge clk) if (c_we === 1'b1) tb_mem[c_addr] <= c_in;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] model_sum();
      int s = 0;
      foreach (words[i]) s += int'(words[i]);
      return CW'(s % (1 << CW));
   endfunction

   task automatic clobber_mem();
      foreach (tb_mem[i]) tb_mem[i] = ~CW'(i);
   endtask

   task automatic check_mem(input string name, input int upto);
      int nbad = 0;
      int first = -1;
      for (int i = 0; i < upto; i++)
         if (tb_mem[i] !== words[i]) begin
            nbad++;
            if (first < 0) first = i;
         end
      total++;
      if (nbad != 0) begin
         bad++;
         $display("FAIL %s: %0d wrong entries, first addr %0d got %h want %h",
                  name, nbad, first, tb_mem[first], words[first]);
      end
   endtask

   task automatic do_start(input string name);
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({busy, c_we, c_addr, c_in, err_code, coeff_ok, done} !== {1'b1, 1'b1, AW'(0), CW'(0), 2'd0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL %s start: busy=%b we=%b addr=%0d in=%h err=%0d ok=%b done=%b want 1 1 0 0 0 0 0",
                  name, busy, c_we, c_addr, c_in, err_code, coeff_ok, done);
      end
   endtask

   // Streams words[from..to-1] with random gaps; checks the write appears one cycle after each accept.
   task automatic stream(input string name, input int from, input int to, input int max_gap);
      for (int k = from; k < to; k++) begin
         int gap = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
         repeat (gap) tick();
         s_valid = 1'b1;
         s_data  = words[k];
         #1;
         total++;
         if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready word %0d: got %b want 1", name, k, s_ready);
         end
         tick();
         s_valid = 1'b0;
         s_data  = CW'($urandom);
         total++;
         if (c_we !== 1'b1 || c_addr !== AW'(k) || c_in !== words[k]) begin
            bad++;
            $display("FAIL %s write %0d: we=%b addr=%0d in=%h want 1 %0d %h",
                     name, k, c_we, c_addr, c_in, k, words[k]);
         end
      end
   endtask

   task automatic send_csum(input string name, input logic [CW-1:0] value, input logic [1:0] exp_err);
      s_valid = 1'b1;
      s_data  = value;
      tick();
      s_valid = 1'b0;
      total++;
      if ({done, err_code, coeff_ok, c_we, busy} !== {1'b1, exp_err, exp_err == 2'd0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL %s end: done=%b err=%0d ok=%b we=%b busy=%b want 1 %0d %b 0 0",
                  name, done, err_code, coeff_ok, c_we, busy, exp_err, exp_err == 2'd0);
      end
      tick();
      total++;
      if (done !== 1'b0 || err_code !== exp_err) begin
         bad++;
         $display("FAIL %s after: done=%b err=%0d want 0 %0d", name, done, err_code, exp_err);
      end
   endtask

   task automatic fill_ramp();
      words.delete();
      for (int i = 1; i <= NC; i++) words.push_back(CW'(i));
   endtask

   task automatic fill_random();
      words.delete();
      for (int i = 0; i < NC; i++) words.push_back(CW'($urandom));
   endtask

   task automatic test_reset();
      nrst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
      #12;
      total++;
      if ({c_we, c_addr, c_in, busy, done, err_code, coeff_ok, s_ready} !== '0) begin
         bad++;
         $display("FAIL reset: we=%b addr=%0d in=%h busy=%b done=%b err=%0d ok=%b rdy=%b want all 0",
                  c_we, c_addr, c_in, busy, done, err_code, coeff_ok, s_ready);
      end
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_ramp();
      fill_ramp();
      total++;
      if (model_sum() !== 16'h2040) begin
         bad++;
         $display("FAIL ramp model sum: got %h want 2040", model_sum());
      end
      clobber_mem();
      do_start("ramp");
      stream("ramp", 0, NC, 0);
      send_csum("ramp", model_sum(), 2'd0);
      check_mem("ramp mem", NC);
   endtask

   task automatic test_bad_csum();
      fill_ramp();
      clobber_mem();
      do_start("badsum");
      stream("badsum", 0, NC, 0);
      send_csum("badsum", model_sum() + 1'b1, 2'd1);
      check_mem("badsum mem", NC);
   endtask

   task automatic test_gaps();
      fill_ramp();
      clobber_mem();
      do_start("gaps");
      stream("gaps", 0, NC, 50);
      repeat ($urandom_range(50)) tick();
      send_csum("gaps", model_sum(), 2'd0);
      check_mem("gaps mem", NC);
   endtask

   task automatic test_timeout();
      int n = 0;
      fill_random();
      do_start("timeout");
      stream("timeout", 0, 41, 0);
      while (done !== 1'b1 && n < 2 * TIMEOUT) begin
         tick();
         n++;
      end
      total++;
      if (n != TIMEOUT || {err_code, c_we, busy, coeff_ok} !== {2'd2, 1'b0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL timeout: cycles=%0d err=%0d we=%b busy=%b ok=%b want %0d 2 0 0 0",
                  n, err_code, c_we, busy, coeff_ok, TIMEOUT);
      end
   endtask

   task automatic test_abort();
      fill_random();
      do_start("abort");
      stream("abort", 0, 10, 3);
      s_valid = 1'b1;
      s_data  = words[10];
      abort   = 1'b1;
      #1;
      total++;
      if (s_ready !== 1'b0) begin
         bad++;
         $display("FAIL abort ready: got %b want 0", s_ready);
      end
      tick();
      s_valid = 1'b0;
      abort   = 1'b0;
      total++;
      if ({done, err_code, c_addr, c_we, busy} !== {1'b1, 2'd3, AW'(9), 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL abort end: done=%b err=%0d addr=%0d we=%b busy=%b want 1 3 9 0 0",
                  done, err_code, c_addr, c_we, busy);
      end
      // Abort alone in IDLE does nothing.
      abort = 1'b1;
      tick();
      tick();
      total++;
      if ({done, busy, err_code} !== {1'b0, 1'b0, 2'd3}) begin
         bad++;
         $display("FAIL idle abort: done=%b busy=%b err=%0d want 0 0 3", done, busy, err_code);
      end
      // Start wins over a simultaneous abort; the still-high abort ends the load next cycle.
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({busy, c_we, err_code} !== {1'b1, 1'b1, 2'd0}) begin
         bad++;
         $display("FAIL start+abort: busy=%b we=%b err=%0d want 1 1 0", busy, c_we, err_code);
      end
      tick();
      abort = 1'b0;
      total++;
      if ({done, busy, err_code} !== {1'b1, 1'b0, 2'd3}) begin
         bad++;
         $display("FAIL abort after start: done=%b busy=%b err=%0d want 1 0 3", done, busy, err_code);
      end
   endtask

   task automatic test_restart_and_reset();
      fill_random();
      do_start("restart");
      stream("restart", 0, 5, 2);
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({busy, c_we, c_addr} !== {1'b1, 1'b1, AW'(4)}) begin
         bad++;
         $display("FAIL start in load: busy=%b we=%b addr=%0d want 1 1 4", busy, c_we, c_addr);
      end
      stream("restart", 5, 20, 2);
      nrst = 1'b0;
      #2;
      total++;
      if ({c_we, busy, c_addr, c_in, done, err_code, coeff_ok} !== '0) begin
         bad++;
         $display("FAIL async reset: we=%b busy=%b addr=%0d in=%h done=%b err=%0d ok=%b want all 0",
                  c_we, busy, c_addr, c_in, done, err_code, coeff_ok);
      end
      tick();
      nrst = 1'b1;
      tick();
      fill_random();
      clobber_mem();
      do_start("fresh");
      stream("fresh", 0, NC, 4);
      send_csum("fresh", model_sum(), 2'd0);
      check_mem("fresh mem", NC);
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_bad_csum();
      test_gaps();
      test_timeout();
      test_abort();
      test_restart_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
